// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared types and widths for the interrupt acknowledge sequencer.
package interrupt_ack_sequencer_pkg;

    localparam int unsigned NUM_IRQ     = 8;
    localparam int unsigned VEC_BASE_W  = 5;
    localparam int unsigned VEC_LEVEL_W = 3;

    // Acknowledge sequence: waiting for first INTA, waiting for second INTA, vector presented.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT2 = 2'd1,
        ST_VEC   = 2'd2
    } ack_state_e;

    // Vector byte driven to the CPU on the second acknowledge.
    typedef struct packed {
        logic [VEC_BASE_W-1:0]  base;
        logic [VEC_LEVEL_W-1:0] level;
    } vector_t;

    // One-hot mask for an interrupt level.
    function automatic logic [NUM_IRQ-1:0] level_mask(input logic [VEC_LEVEL_W-1:0] level);
        level_mask = NUM_IRQ'(1) << level;
    endfunction

endpackage

// File: rtl/intr_priority_select.sv
// Fixed-priority pick: lowest-index request strictly below the lowest-index block bit.
module intr_priority_select
    import interrupt_ack_sequencer_pkg::*;
(
    input  logic [NUM_IRQ-1:0]     req,
    input  logic [NUM_IRQ-1:0]     block,
    output logic                   found_c,
    output logic [VEC_LEVEL_W-1:0] level_c
);

    logic open_c;

    // Scan from bit 0 upward; the first block bit closes the window for itself and above.
    always_comb begin
        found_c = 1'b0;
        level_c = '0;
        open_c  = 1'b1;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (block[i]) begin
                open_c = 1'b0;
            end
            if (open_c && req[i] && !found_c) begin
                found_c = 1'b1;
                level_c = VEC_LEVEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Two-INTA interrupt acknowledge sequencer with IRR/ISR bookkeeping and EOI handling.
module interrupt_ack_sequencer
    import interrupt_ack_sequencer_pkg::*;
#(
    parameter bit          AUTO_EOI       = 1'b0,
    parameter int unsigned SPURIOUS_LEVEL = 7
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_IRQ-1:0]                irqIn,
    input  logic                              inta,
    input  logic                              eoiValid,
    input  logic                              eoiSpecific,
    input  logic [VEC_LEVEL_W-1:0]            eoiLevel,
    input  logic [VEC_BASE_W-1:0]             vectorBase,
    output logic                              intOut,
    output logic [VEC_BASE_W+VEC_LEVEL_W-1:0] dataOut,
    output logic                              dataOutValid,
    output logic [NUM_IRQ-1:0]                IRR,
    output logic [NUM_IRQ-1:0]                ISR
);

    localparam logic [VEC_LEVEL_W-1:0] SPUR_LEVEL = VEC_LEVEL_W'(SPURIOUS_LEVEL);

    ack_state_e                        state_q, state_d;
    logic [NUM_IRQ-1:0]                irq_hist_q;
    logic                              hist_valid_q;
    logic [NUM_IRQ-1:0]                irr_q, irr_d;
    logic [NUM_IRQ-1:0]                isr_q, isr_d;
    logic                              int_q, int_d;
    logic [VEC_BASE_W+VEC_LEVEL_W-1:0] data_q, data_d;
    logic                              valid_q, valid_d;
    logic [VEC_LEVEL_W-1:0]            level_q, level_d;
    logic                              spur_q, spur_d;

    logic [NUM_IRQ-1:0]                rise_c;
    logic [NUM_IRQ-1:0]                irr_clr_c;
    logic [NUM_IRQ-1:0]                isr_set_c;
    logic [NUM_IRQ-1:0]                isr_clr_c;
    logic                              sel_found_c;
    logic [VEC_LEVEL_W-1:0]            sel_level_c;
    logic                              eoi_found_c;
    logic [VEC_LEVEL_W-1:0]            eoi_level_c;
    vector_t                           vec_c;

    // Highest-priority request not masked by an in-service level of equal or higher priority.
    intr_priority_select u_req_select (
        .req     (irr_q),
        .block   (isr_q),
        .found_c (sel_found_c),
        .level_c (sel_level_c)
    );

    // Highest-priority in-service level, target of a non-specific EOI.
    intr_priority_select u_eoi_select (
        .req     (isr_q),
        .block   ('0),
        .found_c (eoi_found_c),
        .level_c (eoi_level_c)
    );

    // Rising edges are only trusted once a post-reset history sample exists,
    // so a line held high across reset release never raises a request.
    assign rise_c = hist_valid_q ? (irqIn & ~irq_hist_q) : '0;

    // Next-state, register updates and output values for the acknowledge sequence.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        spur_d    = spur_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        int_d     = 1'b0;
        irr_clr_c = '0;
        isr_set_c = '0;
        isr_clr_c = '0;
        vec_c     = '0;

        if (eoiValid) begin
            if (eoiSpecific) begin
                isr_clr_c = level_mask(eoiLevel);
            end else if (eoi_found_c) begin
                isr_clr_c = level_mask(eoi_level_c);
            end
        end

        case (state_q)
            ST_IDLE: begin
                int_d = sel_found_c;
                if (inta) begin
                    int_d   = 1'b0;
                    state_d = ST_WAIT2;
                    if (sel_found_c) begin
                        level_d   = sel_level_c;
                        spur_d    = 1'b0;
                        isr_set_c = level_mask(sel_level_c);
                        irr_clr_c = level_mask(sel_level_c);
                    end else begin
                        level_d = SPUR_LEVEL;
                        spur_d  = 1'b1;
                    end
                end
            end
            ST_WAIT2: begin
                if (inta) begin
                    vec_c.base  = vectorBase;
                    vec_c.level = level_q;
                    data_d      = vec_c;
                    valid_d     = 1'b1;
                    state_d     = ST_VEC;
                end
            end
            ST_VEC: begin
                state_d = ST_IDLE;
                if (AUTO_EOI && !spur_q) begin
                    isr_clr_c = isr_clr_c | level_mask(level_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Sets take precedence over same-cycle clears on the same bit.
        irr_d = (irr_q & ~irr_clr_c) | rise_c;
        isr_d = (isr_q & ~isr_clr_c) | isr_set_c;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            irq_hist_q   <= '0;
            hist_valid_q <= 1'b0;
            irr_q        <= '0;
            isr_q        <= '0;
            int_q        <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            level_q      <= '0;
            spur_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_hist_q   <= irqIn;
            hist_valid_q <= 1'b1;
            irr_q        <= irr_d;
            isr_q        <= isr_d;
            int_q        <= int_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            level_q      <= level_d;
            spur_q       <= spur_d;
        end
    end

    assign intOut       = int_q;
    assign dataOut      = data_q;
    assign dataOutValid = valid_q;
    assign IRR          = irr_q;
    assign ISR          = isr_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Bench: two sequencers (AUTO_EOI=0 and AUTO_EOI=1) checked against a behavioural model.
module tb_interrupt_ack_sequencer;

    localparam int SPUR = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       inta;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic [4:0] vector_base;

    logic       int0, int1;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic [7:0] irr0, irr1;
    logic [7:0] isr0, isr1;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    interrupt_ack_sequencer #(.AUTO_EOI(1'b0), .SPURIOUS_LEVEL(SPUR)) dut0 (
        .clk(clk), .reset(reset), .irqIn(irq_in), .inta(inta),
        .eoiValid(eoi_valid), .eoiSpecific(eoi_specific), .eoiLevel(eoi_level),
        .vectorBase(vector_base), .intOut(int0), .dataOut(data0),
        .dataOutValid(valid0), .IRR(irr0), .ISR(isr0)
    );

    interrupt_ack_sequencer #(.AUTO_EOI(1'b1), .SPURIOUS_LEVEL(SPUR)) dut1 (
        .clk(clk), .reset(reset), .irqIn(irq_in), .inta(inta),
        .eoiValid(eoi_valid), .eoiSpecific(eoi_specific), .eoiLevel(eoi_level),
        .vectorBase(vector_base), .intOut(int1), .dataOut(data1),
        .dataOutValid(valid1), .IRR(irr1), .ISR(isr1)
    );

    // Abstract model state: acks counts INTA pulses taken in the current sequence
    // (2 means the vector is on the bus this cycle).
    typedef struct packed {
        logic [7:0] prev;
        logic [7:0] irr;
        logic [7:0] isr;
        logic [7:0] data;
        logic       intr;
        logic       valid;
        logic       armed;
        logic       spur;
        logic [1:0] acks;
        logic [2:0] level;
    } mstate_t;

    mstate_t m [2];

    // Index of lowest set bit, 8 when none.
    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    // Lowest pending request strictly below the highest-priority in-service level.
    function automatic int pick(input logic [7:0] irr, input logic [7:0] isr);
        int lim = lowest(isr);
        for (int i = 0; i < lim; i++) if (irr[i]) return i;
        return 8;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input bit auto_eoi,
                                           input logic [7:0] irq, input logic ia,
                                           input logic ev, input logic es,
                                           input logic [2:0] el, input logic [4:0] vb);
        mstate_t n = s;
        int sel = pick(s.irr, s.isr);
        int t;
        n.intr  = 1'b0;
        n.valid = 1'b0;
        if (ev) begin
            t = es ? int'(el) : lowest(s.isr);
            if (t < 8) n.isr[t] = 1'b0;
        end
        if (s.acks == 2'd0) begin
            n.intr = (sel < 8) && !ia;
            if (ia) begin
                n.acks = 2'd1;
                if (sel < 8) begin
                    n.level    = 3'(sel);
                    n.spur     = 1'b0;
                    n.irr[sel] = 1'b0;
                    n.isr[sel] = 1'b1;
                end else begin
                    n.level = 3'(SPUR);
                    n.spur  = 1'b1;
                end
            end
        end else if (s.acks == 2'd1) begin
            if (ia) begin
                n.data  = {vb, s.level};
                n.valid = 1'b1;
                n.acks  = 2'd2;
            end
        end else begin
            n.acks = 2'd0;
            if (auto_eoi && !s.spur) n.isr[s.level] = 1'b0;
        end
        if (s.armed) n.irr = n.irr | (irq & ~s.prev);
        n.prev  = irq;
        n.armed = 1'b1;
        return n;
    endfunction

    // Model advance, mirroring the asynchronous reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m[0] <= '0;
            m[1] <= '0;
        end else begin
            m[0] <= model_next(m[0], 1'b0, irq_in, inta, eoi_valid, eoi_specific, eoi_level, vector_base);
            m[1] <= model_next(m[1], 1'b1, irq_in, inta, eoi_valid, eoi_specific, eoi_level, vector_base);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, want 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-computed value pinned on both the DUT and the model.
    task automatic lit(input string name, input logic [7:0] act, input logic [7:0] mdl,
                       input logic [7:0] exp);
        chk({name, " dut"}, act, exp);
        chk({name, " model"}, mdl, exp);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("int0",   8'(int0),   8'(m[0].intr));
            chk("data0",  data0,      m[0].data);
            chk("valid0", 8'(valid0), 8'(m[0].valid));
            chk("irr0",   irr0,       m[0].irr);
            chk("isr0",   isr0,       m[0].isr);
            chk("int1",   8'(int1),   8'(m[1].intr));
            chk("data1",  data1,      m[1].data);
            chk("valid1", 8'(valid1), 8'(m[1].valid));
            chk("irr1",   irr1,       m[1].irr);
            chk("isr1",   isr1,       m[1].isr);
        end
    end

    // Two INTA pulses with a gap; checks the vector and its one-cycle qualifier.
    task automatic do_ack(input logic [7:0] vec, input string name);
        inta = 1'b1; @(negedge clk);
        inta = 1'b0; @(negedge clk);
        inta = 1'b1; @(negedge clk);
        inta = 1'b0;
        lit({name, " vec0"},   data0,      m[0].data,      vec);
        lit({name, " vec1"},   data1,      m[1].data,      vec);
        lit({name, " valid0"}, 8'(valid0), 8'(m[0].valid), 8'h01);
        @(negedge clk);
        lit({name, " valid0 end"}, 8'(valid0), 8'(m[0].valid), 8'h00);
        lit({name, " vec0 held"},  data0,      m[0].data,      vec);
    endtask

    initial begin
        reset        = 1'b1;
        irq_in       = 8'h00;
        inta         = 1'b0;
        eoi_valid    = 1'b0;
        eoi_specific = 1'b0;
        eoi_level    = 3'd0;
        vector_base  = 5'h10;
        repeat (2) @(negedge clk);
        lit("rst irr0",  irr0,       m[0].irr,       8'h00);
        lit("rst isr0",  isr0,       m[0].isr,       8'h00);
        lit("rst int0",  8'(int0),   8'(m[0].intr),  8'h00);
        lit("rst data0", data0,      m[0].data,      8'h00);
        reset  = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single request on level 3.
        irq_in = 8'h08;
        repeat (2) @(negedge clk);
        lit("A irr0", irr0,     m[0].irr,      8'h08);
        lit("A int0", 8'(int0), 8'(m[0].intr), 8'h01);
        do_ack(8'h83, "A");
        lit("A isr0", isr0, m[0].isr, 8'h08);
        lit("A isr1", isr1, m[1].isr, 8'h00);
        lit("A irr0 clr", irr0, m[0].irr, 8'h00);

        // Lower priority blocked by in-service level 3; higher priority preempts.
        irq_in = 8'h28;
        repeat (3) @(negedge clk);
        lit("B int0 blocked", 8'(int0), 8'(m[0].intr), 8'h00);
        lit("B irr0",         irr0,     m[0].irr,      8'h20);
        lit("B int1 open",    8'(int1), 8'(m[1].intr), 8'h01);
        irq_in = 8'h2A;
        repeat (3) @(negedge clk);
        lit("B int0 preempt", 8'(int0), 8'(m[0].intr), 8'h01);
        do_ack(8'h81, "B");
        lit("B isr0", isr0, m[0].isr, 8'h0A);

        // Non-specific then specific EOI.
        eoi_valid = 1'b1; eoi_specific = 1'b0;
        @(negedge clk);
        eoi_valid = 1'b0;
        lit("C ns eoi", isr0, m[0].isr, 8'h08);
        eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3;
        @(negedge clk);
        eoi_valid = 1'b0;
        lit("C sp eoi", isr0, m[0].isr, 8'h00);
        repeat (2) @(negedge clk);
        lit("C int0 unblocked", 8'(int0), 8'(m[0].intr), 8'h01);
        do_ack(8'h85, "C");
        lit("C isr0", isr0, m[0].isr, 8'h20);
        lit("C isr1 auto", isr1, m[1].isr, 8'h00);
        eoi_valid = 1'b1; eoi_specific = 1'b0;
        @(negedge clk);
        eoi_valid = 1'b0;

        // Acknowledge with nothing pending gives the spurious level.
        do_ack(8'h87, "D");
        lit("D isr0", isr0, m[0].isr, 8'h00);
        lit("D irr0", irr0, m[0].irr, 8'h00);

        // Reset in the middle of a sequence, with a line held high through release.
        irq_in = 8'h00;
        @(negedge clk);
        irq_in = 8'h01;
        repeat (3) @(negedge clk);
        lit("E int0", 8'(int0), 8'(m[0].intr), 8'h01);
        inta = 1'b1; @(negedge clk);
        inta = 1'b0;
        reset = 1'b1;
        #1;
        chk("E rst int0",   8'(int0),   8'h00);
        chk("E rst valid0", 8'(valid0), 8'h00);
        chk("E rst data0",  data0,      8'h00);
        chk("E rst irr0",   irr0,       8'h00);
        chk("E rst isr0",   isr0,       8'h00);
        chk("E rst isr1",   isr1,       8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        lit("E irr0 no edge", irr0,       m[0].irr,       8'h00);
        lit("E int0 quiet",   8'(int0),   8'(m[0].intr),  8'h00);
        lit("E valid0",       8'(valid0), 8'(m[0].valid), 8'h00);
        do_ack(8'h87, "E");

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            irq_in       = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            inta         = ($urandom_range(0, 3) == 0);
            eoi_valid    = ($urandom_range(0, 7) == 0);
            eoi_specific = 1'($urandom_range(0, 1));
            eoi_level    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) vector_base = 5'($urandom);
            reset        = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        inta  = 1'b0;
        eoi_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
